burst_sequencer: RTL and testbench
==================================

# burst_sequencer

Sequences repeated acquisition bursts through the gated stream controller. Latches a burst configuration on `start`, drives the controller's `samples` and `trig` inputs, watches its output stream for the `tlast` handshake, waits a programmable gap, and re-triggers until the requested burst count completes. Sits beside the stream controller in the acquisition path, with its control inputs on the host register interface.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the burst counter and `cfg_bursts`.

Ports:
- `clk` input 1: single clock for all logic.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: level sampled each cycle; honoured only in IDLE.
- `abort` input 1: stop sequencing; honoured in any non-IDLE state.
- `cfg_samples` input 32: samples per burst.
- `cfg_bursts` input CNT_WIDTH: number of bursts.
- `cfg_gap` input 32: idle cycles between the end of one burst and the next trigger.
- `mon_tvalid` input 1: controller output stream `tvalid` (monitor only).
- `mon_tready` input 1: controller output stream `tready` (monitor only).
- `mon_tlast` input 1: controller output stream `tlast` (monitor only).
- `samples` output 32: to controller `samples`; registered.
- `trig` output 1: to controller `trig`; registered one-cycle pulse.
- `busy` output 1: high in any state other than IDLE.
- `burst_idx` output CNT_WIDTH: number of bursts completed in the current run.
- `done` output 1: one-cycle pulse when the final burst completes.
- `aborted` output 1: one-cycle pulse when an abort is taken.

## Operation
- States: IDLE, TRIG, WAIT_LAST, GAP.
- IDLE: `start`=1 latches `cfg_samples` into `samples`, `cfg_bursts` into `bursts_r` and `cfg_gap` into `gap_r`, and clears `burst_idx`.
  - If the latched `cfg_samples`=0 or `cfg_bursts`=0: pulse `done` next cycle, stay in IDLE, never assert `trig`.
  - Otherwise go to TRIG.
- TRIG: `trig`=1 for exactly this one cycle. Go to WAIT_LAST.
- WAIT_LAST: a burst ends on `mon_tvalid & mon_tready & mon_tlast`. On that cycle, increment `burst_idx`.
  - If the new `burst_idx` == `bursts_r`: pulse `done` and go to IDLE.
  - Else if `gap_r`=0: go directly to TRIG.
  - Else: load the gap counter with `gap_r` and go to GAP.
- GAP: decrement the gap counter each cycle. When it reaches 1, go to TRIG. Exactly `gap_r` cycles are spent in GAP.
- Abort: `abort`=1 in TRIG, WAIT_LAST or GAP goes to IDLE with `trig`=0 and a one-cycle `aborted` pulse. `done` is not pulsed. `burst_idx` holds its value.
- Abort takes priority over a same-cycle `tlast` handshake.
- `abort` in IDLE is ignored. `start` outside IDLE is ignored.
- `samples` is held unchanged until the next accepted `start`, so a controller burst still running after an abort terminates correctly.
- `tlast` handshakes seen in IDLE, TRIG or GAP are ignored.
- Width rules: `burst_idx` never exceeds `bursts_r`, so no wrap. The gap counter is 32-bit unsigned.

## Timing
- Reset values: `samples`=0, `trig`=0, `busy`=0, `burst_idx`=0, `done`=0, `aborted`=0; state IDLE.
- `start` at cycle n: `busy`=1 and `trig`=1 at n+1; `samples` is valid at n+1.
- Between any two `trig` pulses there is at least one low cycle (WAIT_LAST lasts at least one cycle), so the controller's rising-edge detector fires once per burst.
- Last handshake at cycle m:
  - `done`=1 and `busy`=0 at m+1.
  - Otherwise the next `trig` is at m+1+`gap_r`.
- `abort` at cycle k: `aborted`=1, `busy`=0 and `trig`=0 at k+1.
- All outputs are registered.
- Reset asserted mid-run returns all outputs to their reset values immediately (asynchronously), with no `done` or `aborted` pulse.

## Structure
- Shared acquisition package holds:
  - state encoding localparams (IDLE=0, TRIG=1, WAIT_LAST=2, GAP=3, 2 bits);
  - `CNT_WIDTH` default.
- Single module. The gap counter and burst counter stay inline; no sub-module is warranted.

## Test plan
- Three bursts: `cfg_samples`=4, `cfg_bursts`=3, `cfg_gap`=5, downstream always ready.
  - Expect exactly 3 `trig` pulses, each 1 cycle.
  - Expect each `trig` to follow the previous `tlast` by 6 cycles.
  - Expect `done` once, one cycle after the third `tlast`, with `burst_idx`=3.
- Zero gap: `cfg_gap`=0, `cfg_bursts`=2.
  - Expect the second `trig` one cycle after the first `tlast`.
  - Expect `trig` low for at least one cycle between the two pulses.
- Degenerate config: `cfg_samples`=0 or `cfg_bursts`=0.
  - Expect `done` one cycle after `start`, no `trig`, `busy` never high.
- Backpressure: `mon_tready` toggled randomly, 16 samples × 2 bursts.
  - Expect completion only on the real `tlast` handshake.
  - Expect `tlast` with `tready`=0 to be ignored.
- Abort during GAP after burst 1 of 4.
  - Expect `aborted` pulse, `busy`=0, `burst_idx`=1, no further `trig`, no `done`.
  - Expect `samples` unchanged.
- Abort and `tlast` handshake in the same cycle on the final burst.
  - Expect `aborted`, not `done`.
- Async reset mid-WAIT_LAST.
  - Expect all outputs zero without waiting for a clock edge.
  - Expect a subsequent `start` to run normally.

Source files
------------

// File: rtl/burst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : burst_sequencer_pkg
//  Description : Shared acquisition constants and state encoding for the
//                burst sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package burst_sequencer_pkg;

    localparam int c_CNT_WIDTH = 16;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_TRIG      = 2'd1;
    localparam logic [1:0] c_ST_WAIT_LAST = 2'd2;
    localparam logic [1:0] c_ST_GAP       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_TRIG      = c_ST_TRIG,
        ST_WAIT_LAST = c_ST_WAIT_LAST,
        ST_GAP       = c_ST_GAP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : burst_sequencer
//  Description : Re-triggers the gated stream controller for a programmed
//                number of bursts, with a programmable gap between bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_sequencer
    import burst_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH = c_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          cfg_samples,
    input  logic [CNT_WIDTH-1:0] cfg_bursts,
    input  logic [31:0]          cfg_gap,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic                 mon_tlast,
    output logic [31:0]          samples,
    output logic                 trig,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] burst_idx,
    output logic                 done,
    output logic                 aborted
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_samples;
    logic [31:0]          r_gap;
    logic [31:0]          r_gap_cnt;
    logic [CNT_WIDTH-1:0] r_bursts;
    logic [CNT_WIDTH-1:0] r_burst_idx;
    logic [CNT_WIDTH-1:0] w_idx_next;
    logic                 r_trig;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_aborted;
    logic                 w_handshake;
    logic                 w_load_cfg;
    logic                 w_idx_inc;
    logic                 w_gap_load;
    logic                 w_gap_dec;
    logic                 w_done_nxt;
    logic                 w_aborted_nxt;

    assign w_handshake = mon_tvalid & mon_tready & mon_tlast;
    assign w_idx_next  = r_burst_idx + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_cfg    = 1'b0;
        w_idx_inc     = 1'b0;
        w_gap_load    = 1'b0;
        w_gap_dec     = 1'b0;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        // Abort wins over everything else, including a same-cycle tlast.
        if (r_state != ST_IDLE && abort) begin
            w_state_nxt   = ST_IDLE;
            w_aborted_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_load_cfg = 1'b1;
                        if (cfg_samples == 32'd0 || cfg_bursts == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_TRIG;
                        end
                    end
                end
                ST_TRIG: begin
                    w_state_nxt = ST_WAIT_LAST;
                end
                ST_WAIT_LAST: begin
                    if (w_handshake) begin
                        w_idx_inc = 1'b1;
                        if (w_idx_next == r_bursts) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (r_gap == 32'd0) begin
                            w_state_nxt = ST_TRIG;
                        end else begin
                            w_gap_load  = 1'b1;
                            w_state_nxt = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 32'd1) begin
                        w_state_nxt = ST_TRIG;
                    end else begin
                        w_gap_dec = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // samples is only rewritten on an accepted start so an aborted
    // controller burst still sees a stable length.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_samples   <= 32'd0;
            r_bursts    <= '0;
            r_gap       <= 32'd0;
            r_gap_cnt   <= 32'd0;
            r_burst_idx <= '0;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            if (w_load_cfg) begin
                r_samples   <= cfg_samples;
                r_bursts    <= cfg_bursts;
                r_gap       <= cfg_gap;
                r_burst_idx <= '0;
            end else if (w_idx_inc) begin
                r_burst_idx <= w_idx_next;
            end
            if (w_gap_load) begin
                r_gap_cnt <= r_gap;
            end else if (w_gap_dec) begin
                r_gap_cnt <= r_gap_cnt - 32'd1;
            end
            r_trig    <= (w_state_nxt == ST_TRIG);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    assign samples   = r_samples;
    assign trig      = r_trig;
    assign busy      = r_busy;
    assign burst_idx = r_burst_idx;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_sequencer
//  Description : Self-checking bench for burst_sequencer; emulates the stream
//                controller output and predicts trig/done timing arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_sequencer;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [31:0]   cfg_samples;
    logic [CW-1:0] cfg_bursts;
    logic [31:0]   cfg_gap;
    logic          mon_tvalid;
    logic          mon_tready;
    logic          mon_tlast;
    logic [31:0]   samples;
    logic          trig;
    logic          busy;
    logic [CW-1:0] burst_idx;
    logic          done;
    logic          aborted;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int trig_q[$];
    int done_q[$];
    int ab_q[$];
    int hs_log[$];

    burst_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .cfg_samples(cfg_samples),
        .cfg_bursts (cfg_bursts),
        .cfg_gap    (cfg_gap),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .mon_tlast  (mon_tlast),
        .samples    (samples),
        .trig       (trig),
        .busy       (busy),
        .burst_idx  (burst_idx),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output event log, sampled mid-cycle; cycle stamps follow the input
    // cycle in which the stimulus was applied.
    always @(negedge clk) begin
        if (trig === 1'b1)    trig_q.push_back(cyc);
        if (done === 1'b1)    done_q.push_back(cyc);
        if (aborted === 1'b1) ab_q.push_back(cyc);
    end

    // Reference: first trig one cycle after start, later trigs gap+1 after
    // the previous burst's final handshake.
    function automatic int exp_trig(input int k, input int sc, input int gap);
        return (k == 0) ? sc + 1 : hs_log[k-1] + 1 + gap;
    endfunction

    task automatic clear_logs();
        trig_q.delete();
        done_q.delete();
        ab_q.delete();
        hs_log.delete();
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        abort      = 1'b0;
        mon_tvalid = 1'b0;
        mon_tready = 1'b1;
        mon_tlast  = 1'b0;
    endtask

    task automatic do_start(input int ns, input int nb, input int gap, output int sc);
        @(negedge clk);
        cfg_samples = 32'(ns);
        cfg_bursts  = CW'(nb);
        cfg_gap     = 32'(gap);
        start       = 1'b1;
        sc          = cyc;
        @(negedge clk);
        start       = 1'b0;
        cfg_samples = $urandom;
        cfg_bursts  = CW'($urandom);
        cfg_gap     = $urandom;
    endtask

    task automatic wait_trig();
        int n = 0;
        while (trig !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (trig !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_trig: trig=%b after 200 cycles, want 1", trig);
        end
    endtask

    // Emulates the controller stream for one burst of n samples.
    task automatic drive_burst(input int n, input bit bp, input bit ab_last);
        int  sent   = 0;
        int  budget = 0;
        int  hs     = -1;
        bit  held   = 1'b0;
        @(negedge clk);
        while (sent < n && budget < 1000) begin
            mon_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            mon_tlast  = (sent == n - 1);
            if (bp && mon_tlast && !held) begin
                mon_tvalid = 1'b1;
                mon_tready = 1'b0;
                held       = 1'b1;
            end else begin
                mon_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (mon_tvalid && mon_tready) begin
                sent++;
                if (sent == n) begin
                    hs = cyc;
                    if (ab_last) abort = 1'b1;
                end
            end
            budget++;
            @(negedge clk);
        end
        idle_inputs();
        if (hs < 0) begin
            checks++;
            errors++;
            $display("FAIL drive_burst: sent %0d of %0d samples", sent, n);
        end
        hs_log.push_back(hs);
    endtask

    task automatic run_bursts(input int ns, input int nb, input int gap, input bit bp, output int sc);
        clear_logs();
        do_start(ns, nb, gap, sc);
        for (int k = 0; k < nb; k++) begin
            wait_trig();
            drive_burst(ns, bp, 1'b0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        cfg_samples = 32'd0;
        cfg_bursts  = '0;
        cfg_gap     = 32'd0;
        resetn      = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (samples !== 32'd0) begin errors++; $display("FAIL reset_samples: got %0d want 0", samples); end
        checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b want 0", trig); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (burst_idx !== '0) begin errors++; $display("FAIL reset_burst_idx: got %0d want 0", burst_idx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b want 0", aborted); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_three_bursts();
        int sc;
        run_bursts(4, 3, 5, 1'b0, sc);
        checks++; if (trig_q.size() != 3) begin errors++; $display("FAIL three_trig_count: got %0d want 3", trig_q.size()); end
        for (int k = 0; k < 3 && k < trig_q.size(); k++) begin
            checks++;
            if (trig_q[k] != exp_trig(k, sc, 5)) begin
                errors++;
                $display("FAIL three_trig_time[%0d]: got %0d want %0d", k, trig_q[k], exp_trig(k, sc, 5));
            end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != hs_log[2] + 1) begin errors++; $display("FAIL three_done: got %0d pulses first at %0d want 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, hs_log[2] + 1); end
        checks++; if (burst_idx !== CW'(3)) begin errors++; $display("FAIL three_burst_idx: got %0d want 3", burst_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL three_busy: got %b want 0", busy); end
        checks++; if (samples !== 32'd4) begin errors++; $display("FAIL three_samples: got %0d want 4", samples); end
    endtask

    task automatic test_zero_gap();
        int sc;
        int ns = $urandom_range(1, 8);
        run_bursts(ns, 2, 0, 1'b0, sc);
        checks++; if (trig_q.size() != 2) begin errors++; $display("FAIL zgap_trig_count: got %0d want 2", trig_q.size()); end
        if (trig_q.size() == 2) begin
            checks++; if (trig_q[1] != hs_log[0] + 1) begin errors++; $display("FAIL zgap_second_trig: got %0d want %0d", trig_q[1], hs_log[0] + 1); end
            checks++; if (trig_q[1] - trig_q[0] < 2) begin errors++; $display("FAIL zgap_trig_low: spacing %0d want >=2", trig_q[1] - trig_q[0]); end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != hs_log[1] + 1) begin errors++; $display("FAIL zgap_done: got %0d pulses want 1 at %0d", done_q.size(), hs_log[1] + 1); end
        checks++; if (burst_idx !== CW'(2)) begin errors++; $display("FAIL zgap_burst_idx: got %0d want 2", burst_idx); end
    endtask

    task automatic test_degenerate();
        for (int v = 0; v < 2; v++) begin
            int sc;
            int ns = (v == 0) ? 0 : $urandom_range(1, 9);
            int nb = (v == 0) ? $urandom_range(1, 9) : 0;
            bit busy_seen;
            clear_logs();
            do_start(ns, nb, 3, sc);
            busy_seen = busy;
            repeat (4) begin
                @(negedge clk);
                busy_seen |= busy;
            end
            checks++; if (done_q.size() != 1 || done_q[0] != sc + 1) begin errors++; $display("FAIL degen%0d_done: got %0d pulses want 1 at %0d", v, done_q.size(), sc + 1); end
            checks++; if (trig_q.size() != 0) begin errors++; $display("FAIL degen%0d_trig: got %0d pulses want 0", v, trig_q.size()); end
            checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL degen%0d_busy: got %b want 0", v, busy_seen); end
            checks++; if (samples !== 32'(ns)) begin errors++; $display("FAIL degen%0d_samples: got %0d want %0d", v, samples, ns); end
        end
    endtask

    task automatic test_backpressure();
        int sc;
        int gap = $urandom_range(0, 6);
        run_bursts(16, 2, gap, 1'b1, sc);
        checks++; if (trig_q.size() != 2) begin errors++; $display("FAIL bp_trig_count: got %0d want 2", trig_q.size()); end
        if (trig_q.size() == 2) begin
            checks++; if (trig_q[1] != exp_trig(1, sc, gap)) begin errors++; $display("FAIL bp_second_trig: got %0d want %0d", trig_q[1], exp_trig(1, sc, gap)); end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != hs_log[1] + 1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1 at %0d", done_q.size(), hs_log[1] + 1); end
        checks++; if (burst_idx !== CW'(2)) begin errors++; $display("FAIL bp_burst_idx: got %0d want 2", burst_idx); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int sc;
            int ns  = $urandom_range(1, 6);
            int nb  = $urandom_range(1, 4);
            int gap = $urandom_range(0, 6);
            bit bp  = 1'($urandom_range(0, 1));
            int bad = 0;
            run_bursts(ns, nb, gap, bp, sc);
            checks++; if (trig_q.size() != nb) begin errors++; $display("FAIL rand%0d_trig_count: got %0d want %0d", it, trig_q.size(), nb); end
            for (int k = 0; k < trig_q.size() && k < nb; k++)
                if (trig_q[k] != exp_trig(k, sc, gap)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_trig_times: got %0d misplaced want 0", it, bad); end
            checks++; if (done_q.size() != 1 || done_q[0] != hs_log[nb-1] + 1) begin errors++; $display("FAIL rand%0d_done: got %0d pulses want 1 at %0d", it, done_q.size(), hs_log[nb-1] + 1); end
            checks++; if (burst_idx !== CW'(nb)) begin errors++; $display("FAIL rand%0d_burst_idx: got %0d want %0d", it, burst_idx, nb); end
        end
    endtask

    task automatic test_abort_gap();
        int sc;
        int ns = $urandom_range(1, 8);
        clear_logs();
        do_start(ns, 4, 10, sc);
        wait_trig();
        drive_burst(ns, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abgap_aborted: got %b want 1", aborted); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abgap_busy: got %b want 0", busy); end
        checks++; if (trig !== 1'b0) begin errors++; $display("FAIL abgap_trig: got %b want 0", trig); end
        checks++; if (burst_idx !== CW'(1)) begin errors++; $display("FAIL abgap_burst_idx: got %0d want 1", burst_idx); end
        repeat (30) @(negedge clk);
        checks++; if (trig_q.size() != 1) begin errors++; $display("FAIL abgap_trig_count: got %0d want 1", trig_q.size()); end
        checks++; if (done_q.size() != 0) begin errors++; $display("FAIL abgap_done: got %0d pulses want 0", done_q.size()); end
        checks++; if (ab_q.size() != 1) begin errors++; $display("FAIL abgap_abort_count: got %0d want 1", ab_q.size()); end
        checks++; if (samples !== 32'(ns)) begin errors++; $display("FAIL abgap_samples: got %0d want %0d", samples, ns); end
    endtask

    task automatic test_abort_tlast();
        int sc;
        int ns = $urandom_range(1, 8);
        clear_logs();
        do_start(ns, 2, 0, sc);
        wait_trig();
        drive_burst(ns, 1'b0, 1'b0);
        wait_trig();
        drive_burst(ns, 1'b0, 1'b1);
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abtl_aborted: got %b want 1", aborted); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abtl_done: got %b want 0", done); end
        checks++; if (burst_idx !== CW'(1)) begin errors++; $display("FAIL abtl_burst_idx: got %0d want 1", burst_idx); end
        repeat (3) @(negedge clk);
        checks++; if (done_q.size() != 0) begin errors++; $display("FAIL abtl_done_count: got %0d want 0", done_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abtl_busy: got %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int sc;
        clear_logs();
        do_start(8, 3, 0, sc);
        wait_trig();
        drive_burst(8, 1'b0, 1'b0);
        wait_trig();
        @(negedge clk);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (samples !== 32'd0) begin errors++; $display("FAIL arst_samples: got %0d want 0", samples); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        checks++; if (burst_idx !== '0) begin errors++; $display("FAIL arst_burst_idx: got %0d want 0", burst_idx); end
        checks++; if ({trig, done, aborted} !== 3'b000) begin errors++; $display("FAIL arst_pulses: got %b want 000", {trig, done, aborted}); end
        idle_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        checks++; if (done_q.size() != 0 || ab_q.size() != 0) begin errors++; $display("FAIL arst_no_pulse: got done=%0d aborted=%0d want 0 0", done_q.size(), ab_q.size()); end
        run_bursts(3, 1, 0, 1'b0, sc);
        checks++; if (trig_q.size() != 1 || trig_q[0] != sc + 1) begin errors++; $display("FAIL arst_rerun_trig: got %0d pulses want 1 at %0d", trig_q.size(), sc + 1); end
        checks++; if (done_q.size() != 1 || done_q[0] != hs_log[0] + 1) begin errors++; $display("FAIL arst_rerun_done: got %0d pulses want 1 at %0d", done_q.size(), hs_log[0] + 1); end
        checks++; if (burst_idx !== CW'(1)) begin errors++; $display("FAIL arst_rerun_idx: got %0d want 1", burst_idx); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_three_bursts();
        test_zero_gap();
        test_degenerate();
        test_backpressure();
        test_random();
        test_abort_gap();
        test_abort_tlast();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
